// File: rtl/corevx_cache_arbiter.sv
// corevx_cache_arbiter: shares one corevx cache port between M0 (fetch) and M1 (execute).
// One requester owns the cache for a whole transaction. The owner's cmd/address/store data
// reach the cache with no added latency, and the cache response and load data go back to the
// owner only. The other port sees WAIT with zero load data.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   m0_cmd/m0_address               M0 request in
//   m0_response/m0_load_data        M0 response out
//   m1_cmd/m1_address/m1_store_data M1 request in
//   m1_response/m1_load_data        M1 response out
//   c_reset_done                    cache init complete in, mirrored on m0/m1_reset_done
//   c_cmd/c_address/c_store_data    command out to cache
//   c_response/c_load_data          response in from cache
// Parameters:
//   ARB_MODE   0 = round-robin, 1 = fixed priority to M0 with a starvation guard for M1
//   MAX_STARVE ARB_MODE=1: consecutive M0 grants allowed while M1 waits (1..15)
module corevx_cache_arbiter #(
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  m0_cmd,
  input  logic [31:0] m0_address,
  output logic [3:0]  m0_response,
  output logic [31:0] m0_load_data,
  input  logic [3:0]  m1_cmd,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_store_data,
  output logic [3:0]  m1_response,
  output logic [31:0] m1_load_data,
  input  logic        c_reset_done,
  output logic        m0_reset_done,
  output logic        m1_reset_done,
  output logic [3:0]  c_cmd,
  output logic [31:0] c_address,
  output logic [31:0] c_store_data,
  input  logic [3:0]  c_response,
  input  logic [31:0] c_load_data
);

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  // Encodings shared with corevx_cache.svh
  localparam logic [CMD_W-1:0] CACHE_CMD_NONE              = 4'd0;
  localparam logic [CMD_W-1:0] CACHE_RESPONSE_IDLE         = 4'd0;
  localparam logic [CMD_W-1:0] CACHE_RESPONSE_WAIT         = 4'd1;
  localparam logic [CMD_W-1:0] CACHE_RESPONSE_DONE         = 4'd2;
  localparam logic [CMD_W-1:0] CACHE_RESPONSE_ACCESSFAULT  = 4'd3;
  localparam logic [CMD_W-1:0] CACHE_RESPONSE_MISSALIGNED  = 4'd4;
  localparam logic [CMD_W-1:0] CACHE_RESPONSE_PAGEFAULT    = 4'd5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OWN_M0 = 2'd1;
  localparam logic [1:0] ST_OWN_M1 = 2'd2;

  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(MAX_STARVE);

  logic [1:0]       state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;

  logic req0, req1, terminal, win_m1;
  logic owner_valid, owner_m1;

  assign req0     = (m0_cmd != CACHE_CMD_NONE);
  assign req1     = (m1_cmd != CACHE_CMD_NONE);
  assign terminal = (c_response == CACHE_RESPONSE_DONE)        ||
                    (c_response == CACHE_RESPONSE_ACCESSFAULT) ||
                    (c_response == CACHE_RESPONSE_MISSALIGNED) ||
                    (c_response == CACHE_RESPONSE_PAGEFAULT);

  assign m0_reset_done = c_reset_done;
  assign m1_reset_done = c_reset_done;

  // Winner in IDLE: a lone requester wins; on a tie the mode decides
  always_comb begin
    win_m1 = 1'b0;
    if (req1 && !req0) begin
      win_m1 = 1'b1;
    end else if (req1 && req0) begin
      if (ARB_MODE == 0) win_m1 = (last_grant == GRANT_M0);
      else               win_m1 = (starve_cnt == STARVE_LIMIT);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_M1;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Next state, grant bookkeeping and output routing
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    starve_cnt_nxt = starve_cnt;
    owner_valid    = 1'b0;
    owner_m1       = 1'b0;
    c_cmd          = CACHE_CMD_NONE;
    c_address      = '0;
    c_store_data   = '0;
    m0_response    = CACHE_RESPONSE_WAIT;
    m0_load_data   = '0;
    m1_response    = CACHE_RESPONSE_WAIT;
    m1_load_data   = '0;

    if (!c_reset_done) begin
      // Cache not ready: no grants, bookkeeping frozen
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            owner_valid    = 1'b1;
            owner_m1       = win_m1;
            last_grant_nxt = win_m1 ? GRANT_M1 : GRANT_M0;
            // A cache that finishes in the grant cycle leaves us idle
            if (terminal)    state_nxt = ST_IDLE;
            else if (win_m1) state_nxt = ST_OWN_M1;
            else             state_nxt = ST_OWN_M0;
          end
        end
        ST_OWN_M0: begin
          owner_valid = 1'b1;
          owner_m1    = 1'b0;
          if (terminal || (!req0 && c_response == CACHE_RESPONSE_IDLE)) state_nxt = ST_IDLE;
        end
        ST_OWN_M1: begin
          owner_valid = 1'b1;
          owner_m1    = 1'b1;
          if (terminal || (!req1 && c_response == CACHE_RESPONSE_IDLE)) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase

      // Starvation counter tracks M0 grants taken while M1 is waiting
      if (!req1) begin
        starve_cnt_nxt = '0;
      end else if (state == ST_IDLE && (req0 || req1)) begin
        if (win_m1)                         starve_cnt_nxt = '0;
        else if (starve_cnt < STARVE_LIMIT) starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
    end

    if (owner_valid) begin
      if (owner_m1) begin
        c_cmd        = m1_cmd;
        c_address    = m1_address;
        c_store_data = m1_store_data;
        m1_response  = c_response;
        m1_load_data = c_load_data;
      end else begin
        c_cmd        = m0_cmd;
        c_address    = m0_address;
        m0_response  = c_response;
        m0_load_data = c_load_data;
      end
    end

    // Reset quiets every output immediately, independent of the clock
    if (!rst_n) begin
      c_cmd        = CACHE_CMD_NONE;
      c_address    = '0;
      c_store_data = DATA_W'(0);
      m0_response  = CACHE_RESPONSE_IDLE;
      m0_load_data = '0;
      m1_response  = CACHE_RESPONSE_IDLE;
      m1_load_data = '0;
    end
  end

endmodule

// File: tb/tb_corevx_cache_arbiter.sv
// Bench for corevx_cache_arbiter: a round-robin instance and a fixed-priority instance
// (MAX_STARVE=2) share the same stimulus; each vector names the instance it checks.
module tb_corevx_cache_arbiter;

  localparam logic [3:0] N = 4'd0, LD = 4'd1, EX = 4'd3;
  localparam logic [3:0] RI = 4'd0, RW = 4'd1, RD = 4'd2, RPF = 4'd5;
  localparam logic [31:0] SD = 32'hAAAA_5555;

  typedef struct packed {
    logic [3:0]  c_cmd;
    logic [31:0] c_address;
    logic [31:0] c_store_data;
    logic [3:0]  m0_response;
    logic [31:0] m0_load_data;
    logic [3:0]  m1_response;
    logic [31:0] m1_load_data;
    logic [1:0]  reset_done;
  } out_t;

  typedef struct packed {
    logic        dut;
    logic        rst_n;
    logic        rd;
    logic [3:0]  m0c;
    logic [31:0] m0a;
    logic [3:0]  m1c;
    logic [31:0] m1a;
    logic [31:0] m1s;
    logic [3:0]  cr;
    logic [31:0] cl;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  m0_cmd = '0, m1_cmd = '0, c_response = '0;
  logic [31:0] m0_address = '0, m1_address = '0, m1_store_data = '0, c_load_data = '0;
  logic        c_reset_done = 1'b1;

  logic [3:0]  c_cmd0, m0_rsp0, m1_rsp0, c_cmd1, m0_rsp1, m1_rsp1;
  logic [31:0] c_addr0, c_st0, m0_ld0, m1_ld0, c_addr1, c_st1, m0_ld1, m1_ld1;
  logic        m0_rd0, m1_rd0, m0_rd1, m1_rd1;
  out_t        o0, o1;

  vec_t vecs[$];
  out_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  corevx_cache_arbiter #(.ARB_MODE(0), .MAX_STARVE(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .m0_cmd(m0_cmd), .m0_address(m0_address), .m0_response(m0_rsp0), .m0_load_data(m0_ld0),
    .m1_cmd(m1_cmd), .m1_address(m1_address), .m1_store_data(m1_store_data),
    .m1_response(m1_rsp0), .m1_load_data(m1_ld0),
    .c_reset_done(c_reset_done), .m0_reset_done(m0_rd0), .m1_reset_done(m1_rd0),
    .c_cmd(c_cmd0), .c_address(c_addr0), .c_store_data(c_st0),
    .c_response(c_response), .c_load_data(c_load_data));

  corevx_cache_arbiter #(.ARB_MODE(1), .MAX_STARVE(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .m0_cmd(m0_cmd), .m0_address(m0_address), .m0_response(m0_rsp1), .m0_load_data(m0_ld1),
    .m1_cmd(m1_cmd), .m1_address(m1_address), .m1_store_data(m1_store_data),
    .m1_response(m1_rsp1), .m1_load_data(m1_ld1),
    .c_reset_done(c_reset_done), .m0_reset_done(m0_rd1), .m1_reset_done(m1_rd1),
    .c_cmd(c_cmd1), .c_address(c_addr1), .c_store_data(c_st1),
    .c_response(c_response), .c_load_data(c_load_data));

  assign o0 = {c_cmd0, c_addr0, c_st0, m0_rsp0, m0_ld0, m1_rsp0, m1_ld0, m0_rd0, m1_rd0};
  assign o1 = {c_cmd1, c_addr1, c_st1, m0_rsp1, m0_ld1, m1_rsp1, m1_ld1, m0_rd1, m1_rd1};

  task automatic chk_out(input string nm, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cmd=%h addr=%h st=%h r0=%h l0=%h r1=%h l1=%h rd=%b expected cmd=%h addr=%h st=%h r0=%h l0=%h r1=%h l1=%h rd=%b",
               nm, act.c_cmd, act.c_address, act.c_store_data, act.m0_response, act.m0_load_data,
               act.m1_response, act.m1_load_data, act.reset_done,
               exp.c_cmd, exp.c_address, exp.c_store_data, exp.m0_response, exp.m0_load_data,
               exp.m1_response, exp.m1_load_data, exp.reset_done);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic d, input logic r, input logic rd,
                     input logic [3:0] m0c, input logic [31:0] m0a,
                     input logic [3:0] m1c, input logic [31:0] m1a, input logic [31:0] m1s,
                     input logic [3:0] cr, input logic [31:0] cl,
                     input logic [3:0] ec, input logic [31:0] ea, input logic [31:0] es,
                     input logic [3:0] e0, input logic [31:0] l0,
                     input logic [3:0] e1, input logic [31:0] l1);
    vec_t v;
    v.dut = d; v.rst_n = r; v.rd = rd;
    v.m0c = m0c; v.m0a = m0a; v.m1c = m1c; v.m1a = m1a; v.m1s = m1s;
    v.cr = cr; v.cl = cl;
    v.exp.c_cmd = ec; v.exp.c_address = ea; v.exp.c_store_data = es;
    v.exp.m0_response = e0; v.exp.m0_load_data = l0;
    v.exp.m1_response = e1; v.exp.m1_load_data = l1;
    v.exp.reset_done = {rd, rd};
    vecs.push_back(v);
  endtask

  // Alternating grant/DONE pairs with both ports requesting; own[k]=1 means M1 owns pair k
  task automatic add_pairs(input logic d, input logic [5:0] own);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] cl;
      logic        m1o;
      m1o = own[k];
      cl  = 32'h11 * 32'(k + 1);
      add(d, 1, 1, EX, 32'h100, LD, 32'h200, SD, RI, 32'h0,
          m1o ? LD : EX, m1o ? 32'h200 : 32'h100, m1o ? SD : 32'h0,
          m1o ? RW : RI, 32'h0, m1o ? RI : RW, 32'h0);
      add(d, 1, 1, EX, 32'h100, LD, 32'h200, SD, RD, cl,
          m1o ? LD : EX, m1o ? 32'h200 : 32'h100, m1o ? SD : 32'h0,
          m1o ? RW : RD, m1o ? 32'h0 : cl, m1o ? RD : RW, m1o ? cl : 32'h0);
    end
  endtask

  initial begin
    // Reset outputs on both instances while the requesters are active
    add(0, 0, 1, EX, 32'h2000, LD, 32'h3000, SD, RW, 32'h55, N, 0, 0, RI, 0, RI, 0);
    add(1, 0, 1, EX, 32'h2000, LD, 32'h3000, SD, RW, 32'h55, N, 0, 0, RI, 0, RI, 0);
    // Lone M0 fetch: WAIT x3 then DONE, M1 never sees data
    add(0, 1, 1, EX, 32'h2000, N, 0, 0, RI, 32'h0,    EX, 32'h2000, 0, RI, 32'h0,    RW, 0);
    add(0, 1, 1, EX, 32'h2000, N, 0, 0, RW, 32'hdead, EX, 32'h2000, 0, RW, 32'hdead, RW, 0);
    add(0, 1, 1, EX, 32'h2000, N, 0, 0, RW, 32'h0,    EX, 32'h2000, 0, RW, 32'h0,    RW, 0);
    add(0, 1, 1, EX, 32'h2000, N, 0, 0, RW, 32'h0,    EX, 32'h2000, 0, RW, 32'h0,    RW, 0);
    add(0, 1, 1, EX, 32'h2000, N, 0, 0, RD, 32'h13,   EX, 32'h2000, 0, RD, 32'h13,   RW, 0);
    add(0, 1, 1, N, 0, N, 0, 0, RI, 0, N, 0, 0, RW, 0, RW, 0);
    // Round-robin from reset: M0 first, then alternate
    add(0, 0, 1, N, 0, N, 0, 0, RI, 0, N, 0, 0, RI, 0, RI, 0);
    add_pairs(0, 6'b101010);
    // M1 load page-faults, pending M0 granted the cycle after
    add(0, 1, 1, N,  0,        LD, 32'h300, SD, RI,  0, LD, 32'h300, SD, RW, 0, RI,  0);
    add(0, 1, 1, EX, 32'h104,  LD, 32'h300, SD, RW,  0, LD, 32'h300, SD, RW, 0, RW,  0);
    add(0, 1, 1, EX, 32'h104,  LD, 32'h300, SD, RPF, 0, LD, 32'h300, SD, RW, 0, RPF, 0);
    add(0, 1, 1, EX, 32'h104,  N,  0,       0,  RI,  0, EX, 32'h104, 0,  RI, 0, RW,  0);
    add(0, 1, 1, EX, 32'h104,  N,  0,       0,  RD, 32'h44, EX, 32'h104, 0, RD, 32'h44, RW, 0);
    // Cache not ready: nothing granted; on release the round-robin pointer resumes at M1
    add(0, 1, 0, EX, 32'h108, LD, 32'h308, SD, RW, 0, N, 0, 0, RW, 0, RW, 0);
    add(0, 1, 0, EX, 32'h108, LD, 32'h308, SD, RW, 0, N, 0, 0, RW, 0, RW, 0);
    add(0, 1, 1, EX, 32'h108, LD, 32'h308, SD, RI, 0,       LD, 32'h308, SD, RW, 0, RI, 0);
    add(0, 1, 1, EX, 32'h108, LD, 32'h308, SD, RD, 32'h66,  LD, 32'h308, SD, RW, 0, RD, 32'h66);
    // Fixed priority, MAX_STARVE=2: M0, M0, M1, M0, M0, M1
    add(1, 0, 1, N, 0, N, 0, 0, RI, 0, N, 0, 0, RI, 0, RI, 0);
    add_pairs(1, 6'b100100);

    for (int i = 0; i < vecs.size(); i++) begin
      out_t e;
      @(posedge clk);
      #1;
      rst_n = vecs[i].rst_n; c_reset_done = vecs[i].rd;
      m0_cmd = vecs[i].m0c; m0_address = vecs[i].m0a;
      m1_cmd = vecs[i].m1c; m1_address = vecs[i].m1a; m1_store_data = vecs[i].m1s;
      c_response = vecs[i].cr; c_load_data = vecs[i].cl;
      sb.push_back(vecs[i].exp);
      @(negedge clk);
      e = sb.pop_front();
      chk_out($sformatf("vec%0d_dut%0d", i, vecs[i].dut), vecs[i].dut ? o1 : o0, e);
    end

    // Async reset pulse inside one clock period while M1 owns the cache
    @(posedge clk);
    #1;
    m0_cmd = N; m0_address = 32'h0;
    m1_cmd = LD; m1_address = 32'h400; m1_store_data = SD;
    c_response = RI; c_load_data = 32'h0;
    @(negedge clk);
    chk32("t5_grant_m1", 32'(c_cmd0), 32'(LD));
    @(posedge clk);
    #1;
    m0_cmd = EX; m0_address = 32'h500; c_response = RW;
    @(negedge clk);
    chk32("t5_own_m1", 32'(c_cmd0), 32'(LD));
    #1 rst_n = 1'b0;
    #1;
    chk32("t5_rst_cmd", 32'(c_cmd0), 32'(N));
    chk32("t5_rst_addr", c_addr0, 32'h0);
    chk32("t5_rst_m1_rsp", 32'(m1_rsp0), 32'(RI));
    #1 rst_n = 1'b1;
    c_response = RI;
    @(negedge clk);
    chk32("t5_post_cmd", 32'(c_cmd0), 32'(EX));
    chk32("t5_post_addr", c_addr0, 32'h500);
    chk32("t5_post_m1_rsp", 32'(m1_rsp0), 32'(RW));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
